// File: rtl/flip_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flip_inject_ctrl
// Brief    : Frame-level scheduler for the bit-flip error injector. Applies a
//            budget-limited random flip mask to a valid/ready word stream and
//            delivers it through a 1-deep registered output stage, while
//            keeping per-frame and lifetime injected-flip counts.
// Revision : 1.0 - initial release
// ============================================================================
module flip_inject_ctrl #(
    parameter int N         = 3,
    parameter int FRAME_LEN = 8,
    parameter int MAX_FLIPS = 2,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          enable,
    input  logic [N-1:0]  rand_mask,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] frame_flips,
    output logic [CW-1:0] flips_total,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [CW-1:0] c_last_word = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] c_max_flips = CW'(MAX_FLIPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_out_valid;
    logic [N-1:0]  r_out_data;
    logic [CW-1:0] r_word_cnt;
    logic [CW-1:0] r_frame_flips;
    logic [CW-1:0] r_flips_total;
    logic          r_frame_done;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last_word;
    logic          w_flush_done;
    logic          w_frame_start;
    logic [CW-1:0] w_remaining;
    logic [N-1:0]  w_applied;
    logic [CW-1:0] w_popcnt;
    logic [CW:0]   w_total_sum;
    logic [CW-1:0] w_total_nxt;

    // A word moves in only while running and the output slot is free or draining.
    assign w_in_ready    = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept      = in_valid && w_in_ready;
    assign w_last_word   = w_accept && (r_word_cnt == c_last_word);
    // Flush completes on the edge where the output slot becomes empty.
    assign w_flush_done  = (r_state == ST_FLUSH) && (!r_out_valid || out_ready);
    assign w_frame_start = (r_state == ST_IDLE) && start;

    // Frame flip budget still available; frame_flips never exceeds MAX_FLIPS.
    assign w_remaining = c_max_flips - r_frame_flips;

    // Keep the lowest set bits of rand_mask until the remaining budget is used.
    always_comb begin
        w_applied = '0;
        w_popcnt  = '0;
        if (enable) begin
            for (int i = 0; i < N; i++) begin
                if (rand_mask[i] && (w_popcnt < w_remaining)) begin
                    w_applied[i] = 1'b1;
                    w_popcnt     = w_popcnt + CW'(1);
                end
            end
        end
    end

    // Lifetime flip count saturates at all-ones instead of wrapping.
    assign w_total_sum = {1'b0, r_flips_total} + {1'b0, w_popcnt};
    assign w_total_nxt = w_total_sum[CW] ? {CW{1'b1}} : w_total_sum[CW-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: IDLE -> RUN on start, RUN -> FLUSH on last word, FLUSH -> IDLE when drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)        w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_word)  w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_done) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output stage, frame counters and lifetime counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_word_cnt    <= '0;
            r_frame_flips <= '0;
            r_flips_total <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_flush_done;

            if (w_frame_start) begin
                r_word_cnt    <= '0;
                r_frame_flips <= '0;
            end else if (w_accept) begin
                r_word_cnt    <= r_word_cnt + CW'(1);
                r_frame_flips <= r_frame_flips + w_popcnt;
            end

            if (w_accept) begin
                r_flips_total <= w_total_nxt;
                r_out_valid   <= 1'b1;
                r_out_data    <= in_data ^ w_applied;
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign word_cnt    = r_word_cnt;
    assign frame_flips = r_frame_flips;
    assign flips_total = r_flips_total;
    assign frame_done  = r_frame_done;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flip_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flip_inject_ctrl
// Brief    : Scoreboard bench for flip_inject_ctrl (N=3, FRAME_LEN=4,
//            MAX_FLIPS=2, CW=8) driven by hand-computed directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flip_inject_ctrl;

    localparam int N  = 3;
    localparam int FL = 4;
    localparam int MF = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          enable = 1'b1;
    logic [N-1:0]  rand_mask = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready = 1'b1;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] frame_flips;
    logic [CW-1:0] flips_total;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int tot    = 0;
    logic [N-1:0] sb[$];

    flip_inject_ctrl #(.N(N), .FRAME_LEN(FL), .MAX_FLIPS(MF), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable),
        .rand_mask(rand_mask), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .word_cnt(word_cnt), .frame_flips(frame_flips),
        .flips_total(flips_total), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%0h expected=none", out_data);
            end else begin
                chk("out_data", {29'd0, out_data}, {29'd0, sb.pop_front()});
            end
        end
    end

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_in_ready"},    {31'd0, in_ready},    32'd0);
        chk({tag, "_out_valid"},   {31'd0, out_valid},   32'd0);
        chk({tag, "_out_data"},    {29'd0, out_data},    32'd0);
        chk({tag, "_word_cnt"},    {24'd0, word_cnt},    32'd0);
        chk({tag, "_frame_flips"}, {24'd0, frame_flips}, 32'd0);
        chk({tag, "_flips_total"}, {24'd0, flips_total}, 32'd0);
        chk({tag, "_frame_done"},  {31'd0, frame_done},  32'd0);
        chk({tag, "_busy"},        {31'd0, busy},        32'd0);
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one word; push its expected output when the accept edge is reached.
    task automatic send(input logic [N-1:0] d, input logic [N-1:0] m, input logic [N-1:0] x);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        rand_mask = m;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(x);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 expected=1");
        end
    endtask

    // After the last word: frame_done must pulse the cycle after the final transfer.
    task automatic finish_checks(input int exp_ff);
        @(negedge clk);
        chk("pre_done_frame_done", {31'd0, frame_done}, 32'd0);
        chk("pre_done_busy",       {31'd0, busy},       32'd1);
        @(negedge clk);
        chk("frame_done_pulse",    {31'd0, frame_done}, 32'd1);
        chk("done_busy",           {31'd0, busy},       32'd0);
        chk("done_word_cnt",       {24'd0, word_cnt},   FL);
        chk("done_frame_flips",    {24'd0, frame_flips}, exp_ff);
        chk("done_flips_total",    {24'd0, flips_total}, tot);
        chk("done_sb_empty",       sb.size(),           32'd0);
        @(negedge clk);
        chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [11:0] d, input logic [11:0] m,
                             input logic [11:0] x, input logic en, input int exp_ff);
        enable = en;
        do_start();
        for (int i = 0; i < FL; i++) send(d[3*i +: 3], m[3*i +: 3], x[3*i +: 3]);
        tot = (tot + exp_ff > 255) ? 255 : tot + exp_ff;
        finish_checks(exp_ff);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset state, reset mid-traffic, reset beats start.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle_zero("por");
        @(posedge clk); #1;
        reset = 1'b0;
        do_start();
        out_ready = 1'b0;
        send(3'b000, 3'b001, 3'b001);
        @(negedge clk);
        chk("held_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle_zero("rst_mid1");
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle_zero("rst_mid2");
        sb.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle_zero("rst_wins");
        @(posedge clk); #1;

        // Test 2: mask 001 on zero words; budget of 2 spent on the first two words.
        run_frame({3'b000, 3'b000, 3'b000, 3'b000},
                  {3'b001, 3'b001, 3'b001, 3'b001},
                  {3'b000, 3'b000, 3'b001, 3'b001}, 1'b1, 2);

        // Test 3: first word 101 with mask 111 -> bits 0,1 flipped = 110; rest untouched.
        run_frame({3'b000, 3'b111, 3'b010, 3'b101},
                  {3'b111, 3'b111, 3'b111, 3'b111},
                  {3'b000, 3'b111, 3'b010, 3'b110}, 1'b1, 2);

        // Test 4: downstream stall of 3 cycles with a word held.
        enable = 1'b1;
        do_start();
        out_ready = 1'b0;
        send(3'b011, 3'b000, 3'b011);
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_data",  {29'd0, out_data},  32'd3);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b100, 3'b000, 3'b100);
        send(3'b001, 3'b000, 3'b001);
        send(3'b110, 3'b000, 3'b110);
        finish_checks(0);

        // Test 5: pass-through with enable=0 and an all-ones mask.
        run_frame({3'b111, 3'b011, 3'b110, 3'b101},
                  {3'b111, 3'b111, 3'b111, 3'b111},
                  {3'b111, 3'b011, 3'b110, 3'b101}, 1'b0, 0);

        // Test 6: drive flips_total past 255; it must stick at FF while frame_flips stays 2.
        for (int f = 0; f < 128; f++) begin
            run_frame({3'b000, 3'b000, 3'b000, 3'b000},
                      {3'b111, 3'b111, 3'b111, 3'b111},
                      {3'b000, 3'b000, 3'b000, 3'b011}, 1'b1, 2);
        end
        chk("sat_flips_total", {24'd0, flips_total}, 32'hFF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
